// File: rtl/v_black_box_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency two-input core
// between 2**IDW requesters and returns each result tagged with its ID.
module v_black_box_arbiter #(
  parameter int IDW = 2,
  parameter int LAT = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [2**IDW-1:0] REQ,
  input  logic [2**IDW-1:0] A,
  input  logic [2**IDW-1:0] B,
  output logic [2**IDW-1:0] GNT,
  output logic              CORE_IN1,
  output logic              CORE_IN2,
  input  logic              CORE_DOUT,
  output logic              RES,
  output logic [IDW-1:0]    RES_ID,
  output logic              RES_VLD
);

  localparam int N = 2**IDW;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           in1_q, in1_d;
  logic           in2_q, in2_d;
  logic           res_q, res_d;
  logic [IDW-1:0] rid_q, rid_d;
  logic           vld_q, vld_d;

  logic           hit;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] idx;

  // Search starts just past the last grant; IDW-bit add wraps modulo N.
  always_comb begin
    hit = 1'b0;
    sel = ptr_q;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      idx = ptr_q + IDW'(i);
      if (!hit && REQ[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    in1_d   = in1_q;
    in2_d   = in2_q;
    res_d   = res_q;
    rid_d   = rid_q;
    vld_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          gnt_d[sel] = 1'b1;
          in1_d      = A[sel];
          in2_d      = B[sel];
          ptr_d      = sel;
          cnt_d      = 4'(LAT);
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        // cnt_q==1 marks the last of LAT cycles with stable core inputs.
        if (cnt_q == 4'd1) begin
          res_d   = CORE_DOUT;
          rid_d   = ptr_q;
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      ptr_q   <= '1;
      cnt_q   <= '0;
      gnt_q   <= '0;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
      res_q   <= 1'b0;
      rid_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      res_q   <= res_d;
      rid_q   <= rid_d;
      vld_q   <= vld_d;
    end
  end

  assign GNT      = gnt_q;
  assign CORE_IN1 = in1_q;
  assign CORE_IN2 = in2_q;
  assign RES      = res_q;
  assign RES_ID   = rid_q;
  assign RES_VLD  = vld_q;

endmodule

// File: tb/tb_v_black_box_arbiter.sv
// Bench for v_black_box_arbiter: LAT=2 and LAT=1 instances, each with a
// behavioural core model and a result scoreboard.
module tb_v_black_box_arbiter;

  typedef struct packed {
    logic       res;
    logic [1:0] id;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] gnt;
    logic       res;
    logic [1:0] id;
  } vec_t;

  logic CLK;
  logic CLR;

  logic [3:0] req2, a2, b2, gnt2;
  logic       ci1_2, ci2_2, dout2, res2, vld2;
  logic [1:0] rid2;

  logic [3:0] req1, a1, b1, gnt1;
  logic       ci1_1, ci2_1, dout1, res1, vld1;
  logic [1:0] rid1;

  exp_t sb2[$];
  exp_t sb1[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  function automatic logic core_f(input logic x, input logic y);
    return x & ~y;
  endfunction

  v_black_box_arbiter #(.IDW(2), .LAT(2)) u_dut2 (
    .CLK(CLK), .CLR(CLR), .REQ(req2), .A(a2), .B(b2), .GNT(gnt2),
    .CORE_IN1(ci1_2), .CORE_IN2(ci2_2), .CORE_DOUT(dout2),
    .RES(res2), .RES_ID(rid2), .RES_VLD(vld2)
  );

  v_black_box_arbiter #(.IDW(2), .LAT(1)) u_dut1 (
    .CLK(CLK), .CLR(CLR), .REQ(req1), .A(a1), .B(b1), .GNT(gnt1),
    .CORE_IN1(ci1_1), .CORE_IN2(ci2_1), .CORE_DOUT(dout1),
    .RES(res1), .RES_ID(rid1), .RES_VLD(vld1)
  );

  // Core with latency 2: one register stage after the function.
  logic pipe2 = 1'b0;
  always @(posedge CLK) pipe2 <= core_f(ci1_2, ci2_2);
  assign dout2 = pipe2;
  assign dout1 = core_f(ci1_1, ci2_1);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (vld2) begin
      if (sb2.size() == 0) chk("dut2_unexpected_res", 1, 0);
      else begin
        e = sb2.pop_front();
        chk("dut2_res", 32'(res2), 32'(e.res));
        chk("dut2_res_id", 32'(rid2), 32'(e.id));
      end
    end
    if (|gnt2 || vld2)
      chk("dut2_onehot_excl", 32'($onehot0(gnt2) && !(vld2 && |gnt2)), 1);
    if (vld1) begin
      if (sb1.size() == 0) chk("dut1_unexpected_res", 1, 0);
      else begin
        e = sb1.pop_front();
        chk("dut1_res", 32'(res1), 32'(e.res));
        chk("dut1_res_id", 32'(rid1), 32'(e.id));
      end
    end
    if (|gnt1 || vld1)
      chk("dut1_onehot_excl", 32'($onehot0(gnt1) && !(vld1 && |gnt1)), 1);
  end

  task automatic wait_gnt(input bit use1, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      if (use1 ? |gnt1 : |gnt2) begin
        ok = 1'b1;
        return;
      end
    end
    chk("gnt_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int c = 0; c < 30; c++) begin
      if (sb2.size() == 0 && sb1.size() == 0) break;
      @(negedge CLK);
    end
    chk("drain", 32'(sb2.size() + sb1.size()), 0);
    @(negedge CLK);
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    bit ok;
    int last;
    int ng;
    logic [1:0] kc;

    tbl[0] = '{4'b1001, 4'b1001, 4'b0000, 4'b0001, 1'b1, 2'd0};
    tbl[1] = '{4'b1001, 4'b0000, 4'b1001, 4'b1000, 1'b0, 2'd3};
    tbl[2] = '{4'b1001, 4'b0001, 4'b1000, 4'b0001, 1'b1, 2'd0};
    tbl[3] = '{4'b0110, 4'b0110, 4'b0010, 4'b0010, 1'b0, 2'd1};
    tbl[4] = '{4'b0110, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2};
    tbl[5] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd1};
    tbl[6] = '{4'b1111, 4'b0010, 4'b0000, 4'b0100, 1'b0, 2'd2};
    tbl[7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0};
    tbl[8] = '{4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3};
    tbl[9] = '{4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 2'd3};

    CLR = 1'b1;
    req2 = '0; a2 = '0; b2 = '0;
    req1 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge CLK);
    chk("rst_gnt2", 32'(gnt2), 0);
    chk("rst_in1_2", 32'(ci1_2), 0);
    chk("rst_in2_2", 32'(ci2_2), 0);
    chk("rst_res2", 32'(res2), 0);
    chk("rst_rid2", 32'(rid2), 0);
    chk("rst_vld2", 32'(vld2), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_vld1", 32'(vld1), 0);
    CLR = 1'b0;

    // Single request, LAT=2.
    req2 = 4'b0100; a2 = 4'b0100; b2 = 4'b0000;
    sb2.push_back({1'b1, 2'd2});
    @(negedge CLK);
    chk("t1_gnt", 32'(gnt2), 32'h4);
    chk("t1_in1", 32'(ci1_2), 1);
    chk("t1_in2", 32'(ci2_2), 0);
    req2 = '0;
    @(negedge CLK);
    chk("t1_gnt_pulse", 32'(gnt2), 0);
    chk("t1_vld_early", 32'(vld2), 0);
    chk("t1_in1_hold", 32'(ci1_2), 1);
    @(negedge CLK);
    chk("t1_vld", 32'(vld2), 1);
    @(negedge CLK);
    chk("t1_vld_pulse", 32'(vld2), 0);
    chk("t1_res_hold", 32'(res2), 1);
    chk("t1_in1_keep", 32'(ci1_2), 1);
    drain();

    // All four requesting continuously.
    pulse_clr();
    req2 = 4'b1111; a2 = 4'b0110; b2 = 4'b0100;
    for (int k = 0; k < 5; k++)
      sb2.push_back({core_f(a2[k%4], b2[k%4]), 2'(k % 4)});
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(1'b0, ok);
      chk($sformatf("rr%0d_gnt", k), 32'(gnt2), 32'(1 << (k % 4)));
      if (k > 0) chk($sformatf("rr%0d_space", k), 32'(cyc - last), 3);
      last = cyc;
      if (k == 4) req2 = '0;
    end
    drain();

    // Table: one request pattern at a time, pointer starts at 3.
    pulse_clr();
    foreach (tbl[i]) begin
      req2 = tbl[i].req; a2 = tbl[i].a; b2 = tbl[i].b;
      sb2.push_back({tbl[i].res, tbl[i].id});
      wait_gnt(1'b0, ok);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt2), 32'(tbl[i].gnt));
      req2 = '0;
      drain();
    end

    // Request pulsed while busy must never be granted.
    req2 = 4'b0001; a2 = 4'b0001; b2 = 4'b0000;
    sb2.push_back({1'b1, 2'd0});
    wait_gnt(1'b0, ok);
    chk("wd_gnt", 32'(gnt2), 32'h1);
    req2 = 4'b0010; a2 = 4'b0010;
    @(negedge CLK);
    req2 = '0;
    ng = 0;
    repeat (8) begin
      @(negedge CLK);
      if (|gnt2) ng++;
    end
    chk("wd_no_gnt", 32'(ng), 0);
    drain();

    // Reset in the middle of a transaction.
    req2 = 4'b0001; a2 = 4'b0001; b2 = 4'b0000;
    wait_gnt(1'b0, ok);
    chk("mr_gnt", 32'(gnt2), 32'h1);
    chk("mr_in1_pre", 32'(ci1_2), 1);
    req2 = '0;
    @(negedge CLK);
    CLR = 1'b1;
    #1;
    chk("mr_gnt0", 32'(gnt2), 0);
    chk("mr_in1", 32'(ci1_2), 0);
    chk("mr_res", 32'(res2), 0);
    chk("mr_vld", 32'(vld2), 0);
    @(negedge CLK);
    CLR = 1'b0;
    req2 = 4'b0010; a2 = 4'b0010; b2 = 4'b0000;
    @(negedge CLK);
    chk("mr_next_gnt", 32'(gnt2), 32'h2);
    chk("mr_no_vld", 32'(vld2), 0);
    sb2.push_back({1'b1, 2'd1});
    req2 = '0;
    drain();

    // LAT=1 instance: two requesters held, all four operand combos.
    pulse_clr();
    req1 = 4'b0011; a1 = 4'b0000; b1 = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      kc = 2'(k);
      sb1.push_back({core_f(kc[1], kc[0]), 2'(k % 2)});
    end
    last = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(1'b1, ok);
      chk($sformatf("l1_%0d_gnt", k), 32'(gnt1), 32'(1 << (k % 2)));
      if (k > 0) chk($sformatf("l1_%0d_space", k), 32'(cyc - last), 2);
      last = cyc;
      if (k < 2) begin
        kc = 2'(k + 2);
        a1[k%2] = kc[1];
        b1[k%2] = kc[0];
      end
      if (k == 3) req1 = '0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
